// File: rtl/ram_sx_pkg.sv
// Shared definitions for the single-port RAM arbiter.
// Latency: none (types and helper functions only).
// Backpressure: not applicable.
package ram_sx_pkg;

  // Supported requester range.
  localparam int CReqCntMin = 2;
  localparam int CReqCntMax = 4;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_len(input int req_cnt);
    return (req_cnt > 2) ? $clog2(req_cnt) : 1;
  endfunction

  // Low bit of slice idx in a packed per-requester bus of the given slice width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ram_sx_arb_pick.sv
// Rotating-priority picker: first active requester at or after start_i wins.
// Latency: purely combinational.
// Backpressure: none; losing requesters simply stay active.
module ram_sx_arb_pick
  import ram_sx_pkg::*;
#(
  parameter int CReqCnt = 2,
  parameter int CIdxLen = idx_len(CReqCnt)
) (
  input  logic [CReqCnt-1:0] active_i,
  input  logic [CIdxLen-1:0] start_i,
  output logic [CReqCnt-1:0] grant_o,
  output logic [CIdxLen-1:0] idx_o,
  output logic               any_o
);

  int                 cand;
  logic [CIdxLen-1:0] cand_idx;

  // Walk the ring once from start_i; the first active slot found takes the grant.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < CReqCnt; k++) begin
      cand = int'(start_i) + k;
      if (cand >= CReqCnt) begin
        cand = cand - CReqCnt;
      end
      cand_idx = CIdxLen'(cand);
      if (!any_o && active_i[cand_idx]) begin
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
        any_o             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_sx_arb.sv
// Shares one single-port sync RAM among CReqCnt requesters; RAM_SX_ARB_RR_EN selects round-robin.
// Latency: ack combinational in the request cycle, read data one enabled cycle after the ack edge.
// Backpressure: a requester holds its request until acked; AClkHEn=0 stalls grants and read valid.
module ram_sx_arb
  import ram_sx_pkg::*;
#(
  parameter int CReqCnt  = 2,
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128
) (
  input  logic                         AClkH,
  input  logic                         AResetHN,
  input  logic                         AClkHEn,
  input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
  input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
  input  logic [CReqCnt-1:0]           AReqWrEn,
  input  logic [CReqCnt-1:0]           AReqRdEn,
  output logic [CReqCnt-1:0]           AReqAck,
  output logic [CReqCnt*CDataLen-1:0]  AReqMiso,
  output logic [CReqCnt-1:0]           AReqRdVld,
  output logic [CAddrLen-1:0]          AMemAddr,
  output logic [CDataLen-1:0]          AMemMosi,
  output logic                         AMemWrEn,
  output logic                         AMemRdEn,
  input  logic [CDataLen-1:0]          AMemMiso
);

  localparam int                 CIdxLen  = idx_len(CReqCnt);
  localparam logic [CIdxLen-1:0] CIdxLast = CIdxLen'(CReqCnt - 1);

  // Arbitration state: last grant, owner of the read in flight, read-in-flight flag.
  logic [CIdxLen-1:0] last_q, last_d;
  logic [CIdxLen-1:0] rd_own_q, rd_own_d;
  logic               rd_pend_q, rd_pend_d;

  logic [CReqCnt-1:0] active;
  logic [CReqCnt-1:0] pick_grant;
  logic [CIdxLen-1:0] pick_start;
  logic [CIdxLen-1:0] pick_idx;
  logic               pick_any;
  logic               grant_en;
  logic               granted;
  logic               grant_rd;
  logic               rd_vld;

  assign active = AReqWrEn | AReqRdEn;

`ifdef RAM_SX_ARB_RR_EN
  // Round-robin: search begins just after the previous winner.
  assign pick_start = (last_q == CIdxLast) ? '0 : last_q + 1'b1;
`else
  // Fixed priority: lowest index always searched first; last_q is bookkeeping only.
  assign pick_start = '0;
`endif

  ram_sx_arb_pick #(
    .CReqCnt (CReqCnt),
    .CIdxLen (CIdxLen)
  ) u_pick (
    .active_i (active),
    .start_i  (pick_start),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // No grant while the clock is disabled or reset is asserted.
  assign grant_en = AClkHEn & AResetHN;
  assign granted  = grant_en & pick_any;
  assign grant_rd = granted & AReqRdEn[pick_idx];
  assign AReqAck  = granted ? pick_grant : '0;

  // Forward the winner's access to the RAM; all-zero when idle so the RAM holds.
  always_comb begin
    AMemAddr = '0;
    AMemMosi = '0;
    AMemWrEn = 1'b0;
    AMemRdEn = 1'b0;
    if (granted) begin
      AMemAddr = AReqAddr[slice_lo(int'(pick_idx), CAddrLen) +: CAddrLen];
      AMemMosi = AReqMosi[slice_lo(int'(pick_idx), CDataLen) +: CDataLen];
      AMemWrEn = AReqWrEn[pick_idx];
      AMemRdEn = AReqRdEn[pick_idx];
    end
  end

  // Next state: only enabled edges move anything; a read pending across a disabled edge survives.
  always_comb begin
    last_d    = last_q;
    rd_own_d  = rd_own_q;
    rd_pend_d = rd_pend_q;
    if (AClkHEn) begin
      if (granted) begin
        last_d = pick_idx;
      end
      if (grant_rd) begin
        rd_own_d  = pick_idx;
        rd_pend_d = 1'b1;
      end else begin
        rd_pend_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any read in flight and points last grant at the top index.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      last_q    <= CIdxLast;
      rd_own_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_own_q  <= rd_own_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rd_vld = rd_pend_q & AClkHEn;

  // Route the returned RAM word to the owner slice only while valid.
  always_comb begin
    AReqRdVld = '0;
    AReqMiso  = '0;
    if (rd_vld) begin
      AReqRdVld[rd_own_q] = 1'b1;
      AReqMiso[slice_lo(int'(rd_own_q), CDataLen) +: CDataLen] = AMemMiso;
    end
  end

endmodule

// File: tb/tb_ram_sx_arb.sv
// Self-checking bench for ram_sx_arb with four requesters and a deferred-write RAM model.
// Latency: checks ack in the request cycle and read data one enabled cycle later.
// Backpressure: requesters hold requests until acked; clock enable and reset are randomized.
module tb_ram_sx_arb;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_mosi;
  logic [N-1:0]    req_wr;
  logic [N-1:0]    req_rd;
  logic [N-1:0]    ack;
  logic [N*DW-1:0] miso;
  logic [N-1:0]    rdvld;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_mosi;
  logic            mem_wr;
  logic            mem_rd;
  logic [DW-1:0]   mem_miso;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_sx_arb #(
    .CReqCnt  (N),
    .CAddrLen (AW),
    .CDataLen (DW)
  ) dut (
    .AClkH     (clk),
    .AResetHN  (rst_n),
    .AClkHEn   (en),
    .AReqAddr  (req_addr),
    .AReqMosi  (req_mosi),
    .AReqWrEn  (req_wr),
    .AReqRdEn  (req_rd),
    .AReqAck   (ack),
    .AReqMiso  (miso),
    .AReqRdVld (rdvld),
    .AMemAddr  (mem_addr),
    .AMemMosi  (mem_mosi),
    .AMemWrEn  (mem_wr),
    .AMemRdEn  (mem_rd),
    .AMemMiso  (mem_miso)
  );

  // RAM macro: registered address/read enable, write committed on the following enabled edge.
  logic [DW-1:0] ram [0:15];
  logic          ram_init  = 1'b0;
  logic          ram_rd_q  = 1'b0;
  logic [AW-1:0] ram_a_q   = '0;
  logic          ram_wr_q  = 1'b0;
  logic [AW-1:0] ram_wa_q  = '0;
  logic [DW-1:0] ram_wd_q  = '0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      ram[1]   <= {16{8'h11}};
      ram[2]   <= {16{8'h22}};
      ram_init <= 1'b1;
    end else if (en) begin
      if (ram_wr_q) ram[ram_wa_q[3:0]] <= ram_wd_q;
      ram_wr_q <= mem_wr;
      ram_wa_q <= mem_addr;
      ram_wd_q <= mem_mosi;
      ram_rd_q <= mem_rd;
      ram_a_q  <= mem_addr;
    end
  end

  assign mem_miso = ram_rd_q ? ram[ram_a_q[3:0]] : '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model + per-cycle compare ----------------
  logic [N-1:0]  exp_ack = '0;
  int            m_last;
  int            m_own;
  bit            m_pend;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] shadow [0:15];

  initial begin : compare
    int            g;
    logic [N-1:0]  actv;
    logic [N-1:0]  e_vld;
    logic [N*DW-1:0] e_miso;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    shadow[1] = {16{8'h11}};
    shadow[2] = {16{8'h22}};
    m_last = N - 1; m_own = 0; m_pend = 0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ack = '0;
        chk("rst_ack", ack, '0);
        chk("rst_vld", rdvld, '0);
        chk("rst_miso", miso, '0);
        chk("rst_memen", {mem_wr, mem_rd}, '0);
        m_last = N - 1; m_own = 0; m_pend = 0;
      end else begin
        actv = req_wr | req_rd;
        g = -1;
        if (en) begin
`ifdef RAM_SX_ARB_RR_EN
          for (int k = 1; k <= N; k++)
            if (g < 0 && actv[(m_last + k) % N]) g = (m_last + k) % N;
`else
          for (int j = 0; j < N; j++)
            if (g < 0 && actv[j]) g = j;
`endif
        end
        exp_ack = (g >= 0) ? (N'(1) << g) : '0;
        ea = '0; ed = '0;
        if (g >= 0) begin
          ea = req_addr[g*AW +: AW];
          ed = req_mosi[g*DW +: DW];
        end
        chk("ack", ack, exp_ack);
        chk("mem_wr", mem_wr, (g >= 0) ? req_wr[g] : 1'b0);
        chk("mem_rd", mem_rd, (g >= 0) ? req_rd[g] : 1'b0);
        chk("mem_addr", mem_addr, ea);
        chk("mem_mosi", mem_mosi, ed);
        e_vld = '0; e_miso = '0;
        if (m_pend && en) begin
          e_vld[m_own] = 1'b1;
          e_miso[m_own*DW +: DW] = m_rdata;
        end
        chk("rdvld", rdvld, e_vld);
        chk("miso", miso, e_miso);
        // Advance to the state after the coming edge.
        if (en) begin
          if (g >= 0) begin
            m_last = g;
            if (req_rd[g]) begin
              m_pend = 1; m_own = g; m_rdata = shadow[ea[3:0]];
            end else begin
              m_pend = 0;
            end
            if (req_wr[g]) shadow[ea[3:0]] = ed;
          end else begin
            m_pend = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setq(input int i, input bit wr, input bit rd, input int a, input logic [DW-1:0] d);
    req_wr[i] = wr;
    req_rd[i] = rd;
    req_addr[i*AW +: AW] = AW'(a);
    req_mosi[i*DW +: DW] = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < N; i++) setq(i, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin : main
    logic [DW-1:0] vaa, v11, v22;
    logic [N-1:0]  prev;
    int            rr5 [5];
    int            rr4 [4];
    int            own;
    vaa = {16{8'hAA}}; v11 = {16{8'h11}}; v22 = {16{8'h22}};
`ifdef RAM_SX_ARB_RR_EN
    rr5 = '{0, 1, 2, 3, 0};
    rr4 = '{1, 3, 0, 1};
`else
    rr5 = '{0, 0, 0, 0, 0};
    rr4 = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0; en = 1'b1;
    req_addr = '0; req_mosi = '0; req_wr = '0; req_rd = '0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ack", ack, '0);
    chk("idle_memrd", mem_rd, 1'b0);
    chk("idle_memwr", mem_wr, 1'b0);
    chk("idle_miso", miso, '0);

    // Write 0xAA.. to addr 5 by req0, read back by req1 next cycle.
    step(); setq(0, 1'b1, 1'b0, 5, vaa);
    @(negedge clk); chk("wr_ack", ack, 4'b0001);
    step(); setq(0, 1'b0, 1'b0, 0, '0); setq(1, 1'b0, 1'b1, 5, '0);
    @(negedge clk); chk("rd_ack", ack, 4'b0010);
    step(); setq(1, 1'b0, 1'b0, 0, '0);
    @(negedge clk);
    chk("raw_vld", rdvld, 4'b0010);
    chk("raw_dat", miso[DW +: DW], vaa);

    // Two continuous readers of addr 1 and 2.
    step(); setq(0, 1'b0, 1'b1, 1, '0); setq(1, 1'b0, 1'b1, 2, '0);
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
`ifdef RAM_SX_ARB_RR_EN
      chk("alt_ack", ack, (c % 2 == 0) ? 4'b0001 : 4'b0010);
`else
      chk("fix_ack", ack, 4'b0001);
`endif
      if (c > 0) begin
        own = prev[1] ? 1 : 0;
        chk("alt_vld", rdvld, prev);
        chk("alt_dat", miso[own*DW +: DW], own ? v22 : v11);
      end
      prev = ack;
      step();
    end
    clr_all();
    @(negedge clk); chk("alt_vld_last", rdvld, prev);

    // Clock enable low for two cycles between read ack and data.
    step(); setq(0, 1'b0, 1'b1, 2, '0);
    @(negedge clk); chk("ce_ack", ack, 4'b0001);
    step(); setq(0, 1'b0, 1'b0, 0, '0); en = 1'b0; setq(1, 1'b0, 1'b1, 1, '0);
    @(negedge clk); chk("ce_off_ack", ack, '0); chk("ce_off_vld", rdvld, '0);
    step();
    @(negedge clk); chk("ce_off_ack2", ack, '0); chk("ce_off_vld2", rdvld, '0);
    step(); en = 1'b1;
    @(negedge clk);
    chk("ce_on_vld", rdvld, 4'b0001);
    chk("ce_on_dat", miso[0 +: DW], v22);
    chk("ce_on_ack", ack, 4'b0010);
    step(); setq(1, 1'b0, 1'b0, 0, '0);
    @(negedge clk); chk("ce_next_vld", rdvld, 4'b0010); chk("ce_next_dat", miso[DW +: DW], v11);

    // Reset the cycle after a read ack.
    step(); setq(0, 1'b0, 1'b1, 1, '0);
    @(negedge clk); chk("rr_pre_ack", ack, 4'b0001);
    step(); clr_all(); rst_n = 1'b0;
    @(negedge clk); chk("rst_drop_vld", rdvld, '0);
    step(); step(); rst_n = 1'b1;
    @(negedge clk); chk("post_rst_vld", rdvld, '0);
    step();
    for (int i = 0; i < N; i++) setq(i, 1'b0, 1'b1, i, '0);

    // All four active, then requester 2 drops.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); chk("all4_ack", ack, N'(1) << rr5[c]);
      step();
    end
    setq(2, 1'b0, 1'b0, 0, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("skip2_ack", ack, N'(1) << rr4[c]);
      step();
    end
    clr_all();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      en = ($urandom_range(0, 99) < 85);
      for (int i = 0; i < N; i++) begin
        if (!(req_wr[i] || req_rd[i]) || exp_ack[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            int kind;
            kind = $urandom_range(1, 3);
            setq(i, kind[0], kind[1], $urandom_range(0, 15),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
          end else begin
            setq(i, 1'b0, 1'b0, 0, '0);
          end
        end
      end
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
